instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage sitting between the instruction pointer register and the decoder.
- Reads the current IP value and issues one read at a time to instruction memory over a req/ack handshake.
- Presents each fetched word to the decoder with a valid/ready handshake.
- Pulses the IP update strobe so the pointer advances by one instruction. Flush input discards in-flight work when control redirects the IP.

Parameters:
ADDR_WIDTH, 32, width of IP/address path; equals `GR_SIZE` width
INSTR_WIDTH, 32, fetched instruction word width
INSTR_BYTES, 4, IP advance per instruction; power of two; alignment unit

Ports:
clk  input  1  clock; all state on posedge
resetEnable  input  1  reset, asynchronous, active-high
fetchEnable  input  1  run control; low parks the stage in IDLE
flush  input  1  redirect strobe; asserted in the same cycle control pulses IP setEnable
ipValue  input  ADDR_WIDTH  current IP value from the instruction pointer
ipAdjust  output  ADDR_WIDTH  signed adjust to IP; constant INSTR_BYTES
ipUpdateEnable  output  1  one-cycle strobe: IP += ipAdjust
memReq  output  1  instruction memory read request
memAddr  output  ADDR_WIDTH  read address
memAck  input  1  read complete; memData valid this cycle
memData  input  INSTR_WIDTH  read data
instrValid  output  1  instr/instrAddr valid to decoder
instrReady  input  1  decoder accepts when instrValid && instrReady
instr  output  INSTR_WIDTH  fetched instruction
instrAddr  output  ADDR_WIDTH  address the instruction was fetched from
fault  output  1  sticky misaligned-IP fault

Behaviour:
- One clock, reset is asynchronous and active-high. Clock port is `clk`; reset port is `resetEnable`.
- Reset values: state=IDLE; instr=0; instrAddr=0; fault=0. Outputs memReq, ipUpdateEnable and instrValid are all 0.
- States: IDLE, FETCH, DRAIN, HOLD, FAULT.
- IDLE:
  - memReq=0.
  - Next cycle, go to FAULT if fetchEnable && ipValue is misaligned (low log2(INSTR_BYTES) bits != 0).
  - Otherwise, if fetchEnable, go to FETCH.
- FETCH:
  - memReq=1 and memAddr=ipValue.
  - memReq stays high until memAck; a request is never withdrawn.
  - On memAck && !flush: capture instr<=memData and instrAddr<=ipValue. Assert ipUpdateEnable combinationally in this same cycle. Go to HOLD.
  - On memAck && flush: discard the data, no ipUpdateEnable, go to IDLE. The IP holds the new target next cycle.
  - On !memAck && flush: go to DRAIN.
- DRAIN:
  - memReq=1 and memAddr is held at the captured original address, not ipValue.
  - On memAck: discard the data and go to IDLE.
  - A further flush while in DRAIN stays in DRAIN.
- HOLD:
  - instrValid=1. instr and instrAddr are stable until the handshake completes.
  - On instrValid && instrReady && !flush: go to IDLE. The next fetch starts the following cycle if fetchEnable is high.
  - On flush, regardless of instrReady: drop instrValid next cycle and go to IDLE. If flush and instrReady coincide, the transfer still counts as accepted; the decoder owns the flush ordering.
- FAULT:
  - fault=1, memReq=0, instrValid=0.
  - Exits to IDLE only on flush (fault clears) or reset.
- ipUpdateEnable is never asserted in the same cycle as flush. The IP gives update priority over set, so this rule is mandatory.
- ipUpdateEnable is high for exactly one cycle per fetched instruction, and only in FETCH.
- Throughput: one instruction per 3 cycles minimum (IDLE, FETCH with zero-wait ack, HOLD with immediate ready).
- fetchEnable falling mid-operation:
  - The current FETCH/DRAIN/HOLD runs to completion.
  - The stage then parks in IDLE.
- Reset asserted mid-request abandons the transaction. Memory must tolerate memReq dropping on reset.
- memAddr is driven with the FETCH address in FETCH and DRAIN only; it is don't-care otherwise. The bench must not check it outside those states.

Test Plan:
- Reset, ipValue=0x100, fetchEnable=1, memAck after 2 wait cycles with memData=0xDEADBEEF, instrReady=1 -> memReq high 3 cycles at memAddr=0x100. One ipUpdateEnable pulse with ipAdjust=4. instrValid with instr=0xDEADBEEF, instrAddr=0x100.
- Decoder backpressure: instrReady low for 5 cycles in HOLD -> instrValid, instr and instrAddr stable throughout, no new memReq. Accepted on the 6th cycle, then IDLE.
- Flush during a wait: flush one cycle before memAck -> DRAIN, memReq held until ack, data dropped, no ipUpdateEnable. Next fetch uses the new ipValue=0x200.
- Flush coincident with memAck -> ipUpdateEnable stays 0 and instrValid never asserts. The next memAddr equals the redirected ipValue.
- Misaligned ipValue=0x102 with fetchEnable=1 -> fault=1, no memReq. Flush with ipValue=0x104 clears fault and fetches 0x104.
- Async reset asserted in the middle of HOLD, between clock edges -> instrValid, memReq and fault go to 0 immediately. Restart from IDLE.

Source files
------------

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : Fetch stage between the instruction pointer and the decoder.
//            Issues one req/ack read at a time, presents each word to the
//            decoder over valid/ready and pulses the IP advance strobe.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int INSTR_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   resetEnable,
    input  logic                   fetchEnable,
    input  logic                   flush,
    input  logic [ADDR_WIDTH-1:0]  ipValue,
    output logic [ADDR_WIDTH-1:0]  ipAdjust,
    output logic                   ipUpdateEnable,
    output logic                   memReq,
    output logic [ADDR_WIDTH-1:0]  memAddr,
    input  logic                   memAck,
    input  logic [INSTR_WIDTH-1:0] memData,
    output logic                   instrValid,
    input  logic                   instrReady,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instrAddr,
    output logic                   fault
);

    localparam int c_ALIGN_BITS = $clog2(INSTR_BYTES);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_DRAIN = 3'd2;
    localparam logic [2:0] c_HOLD  = 3'd3;
    localparam logic [2:0] c_FAULT = 3'd4;

    logic [2:0]             r_state;
    logic [2:0]             w_next_state;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0]  r_instr_addr;
    logic [ADDR_WIDTH-1:0]  r_req_addr;
    logic                   w_misaligned;
    logic                   w_accept;

    // The IP always advances by exactly one instruction.
    assign ipAdjust  = ADDR_WIDTH'(INSTR_BYTES);
    assign instr     = r_instr;
    assign instrAddr = r_instr_addr;

    generate
        if (INSTR_BYTES > 1) begin : g_align_check
            assign w_misaligned = |ipValue[c_ALIGN_BITS-1:0];
        end else begin : g_no_align_check
            assign w_misaligned = 1'b0;
        end
    endgenerate

    // A fetched word is kept only when the ack is not overridden by a redirect.
    assign w_accept = (r_state == c_FETCH) && memAck && !flush;

    // State register.
    always_ff @(posedge clk or posedge resetEnable) begin
        if (resetEnable) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture fetched word and its address; remember the outstanding request
    // address so a drained request keeps presenting it after the IP moves.
    always_ff @(posedge clk or posedge resetEnable) begin
        if (resetEnable) begin
            r_instr      <= '0;
            r_instr_addr <= '0;
            r_req_addr   <= '0;
        end else begin
            if (r_state == c_FETCH) begin
                r_req_addr <= ipValue;
            end
            if (w_accept) begin
                r_instr      <= memData;
                r_instr_addr <= ipValue;
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next_state   = r_state;
        memReq         = 1'b0;
        memAddr        = ipValue;
        ipUpdateEnable = 1'b0;
        instrValid     = 1'b0;
        fault          = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (fetchEnable) begin
                    w_next_state = w_misaligned ? c_FAULT : c_FETCH;
                end
            end
            c_FETCH: begin
                memReq = 1'b1;
                if (memAck) begin
                    // Update must never coincide with flush: the IP favours update.
                    ipUpdateEnable = !flush;
                    w_next_state   = flush ? c_IDLE : c_HOLD;
                end else if (flush) begin
                    w_next_state = c_DRAIN;
                end
            end
            c_DRAIN: begin
                memReq  = 1'b1;
                memAddr = r_req_addr;
                if (memAck) begin
                    w_next_state = c_IDLE;
                end
            end
            c_HOLD: begin
                instrValid = 1'b1;
                if (instrReady || flush) begin
                    w_next_state = c_IDLE;
                end
            end
            c_FAULT: begin
                fault = 1'b1;
                if (flush) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Brief    : Self-checking bench for instruction_fetch. Models the IP register
//            and per-transaction expectations (address, data, IP movement).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        resetEnable;
    logic        fetchEnable;
    logic        flush;
    logic [31:0] ipValue;
    logic [31:0] ipAdjust;
    logic        ipUpdateEnable;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memData;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [31:0] instrAddr;
    logic        fault;

    // Instruction pointer model: load (bench only), update, then set.
    logic [31:0] ip;
    logic [31:0] flush_target;
    logic [31:0] ip_load_val;
    logic        ip_load;

    int vectors     = 0;
    int miscompares = 0;

    instruction_fetch #(
        .ADDR_WIDTH  (32),
        .INSTR_WIDTH (32),
        .INSTR_BYTES (4)
    ) dut (
        .clk            (clk),
        .resetEnable    (resetEnable),
        .fetchEnable    (fetchEnable),
        .flush          (flush),
        .ipValue        (ipValue),
        .ipAdjust       (ipAdjust),
        .ipUpdateEnable (ipUpdateEnable),
        .memReq         (memReq),
        .memAddr        (memAddr),
        .memAck         (memAck),
        .memData        (memData),
        .instrValid     (instrValid),
        .instrReady     (instrReady),
        .instr          (instr),
        .instrAddr      (instrAddr),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    assign ipValue = ip;

    // IP register behaviour as seen by the fetch stage.
    always @(posedge clk) begin
        if (ip_load)             ip <= ip_load_val;
        else if (ipUpdateEnable) ip <= ip + 32'd4;
        else if (flush)          ip <= flush_target;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One IDLE cycle with fetching enabled; returns the address the fetch will use.
    task automatic idle_cycle(output logic [31:0] a);
        fetchEnable = 1'b1; flush = 1'b0; memAck = 1'b0; instrReady = 1'b0;
        memData = $urandom;
        #1;
        a = ip;
        chk("idle_req", {31'd0, memReq}, 32'd0);
        chk("idle_valid", {31'd0, instrValid}, 32'd0);
        chk("idle_fault", {31'd0, fault}, 32'd0);
        cyc();
    endtask

    // Complete fetch: waits wait-states, stall decoder cycles, optional fetchEnable drop.
    task automatic run_fetch(input int waits, input int stall, input logic [31:0] data, input bit drop);
        logic [31:0] a;
        idle_cycle(a);
        for (int w = 0; w <= waits; w++) begin
            fetchEnable = !drop;
            memAck  = (w == waits);
            memData = (w == waits) ? data : ~data;
            #1;
            chk("fetch_req", {31'd0, memReq}, 32'd1);
            chk("fetch_addr", memAddr, a);
            chk("fetch_upd", {31'd0, ipUpdateEnable}, {31'd0, (w == waits)});
            chk("fetch_valid", {31'd0, instrValid}, 32'd0);
            cyc();
        end
        memAck = 1'b0;
        for (int s = 0; s <= stall; s++) begin
            instrReady = (s == stall);
            #1;
            chk("hold_valid", {31'd0, instrValid}, 32'd1);
            chk("hold_instr", instr, data);
            chk("hold_addr", instrAddr, a);
            chk("hold_req", {31'd0, memReq}, 32'd0);
            chk("hold_upd", {31'd0, ipUpdateEnable}, 32'd0);
            cyc();
        end
        instrReady = 1'b0;
        chk("ip_advance", ip, a + 32'd4);
        if (drop) begin
            for (int p = 0; p < 2; p++) begin
                #1;
                chk("park_req", {31'd0, memReq}, 32'd0);
                cyc();
            end
        end
    endtask

    // Fetch redirected by flush after pre wait cycles, with or without a coincident ack.
    task automatic flush_fetch(input int pre, input bit with_ack, input int drain_waits, input logic [31:0] target);
        logic [31:0] a;
        idle_cycle(a);
        for (int i = 0; i < pre; i++) begin
            #1;
            chk("pre_req", {31'd0, memReq}, 32'd1);
            chk("pre_addr", memAddr, a);
            cyc();
        end
        flush = 1'b1; flush_target = target; memAck = with_ack; memData = $urandom;
        #1;
        chk("flush_req", {31'd0, memReq}, 32'd1);
        chk("flush_addr", memAddr, a);
        chk("flush_upd", {31'd0, ipUpdateEnable}, 32'd0);
        cyc();
        flush = 1'b0; memAck = 1'b0;
        if (!with_ack) begin
            for (int i = 0; i <= drain_waits; i++) begin
                flush  = (i < drain_waits) && ($urandom_range(0, 1) == 1);
                memAck = (i == drain_waits);
                #1;
                chk("drain_req", {31'd0, memReq}, 32'd1);
                chk("drain_addr", memAddr, a);
                chk("drain_upd", {31'd0, ipUpdateEnable}, 32'd0);
                chk("drain_valid", {31'd0, instrValid}, 32'd0);
                cyc();
            end
        end
        flush = 1'b0; memAck = 1'b0;
        chk("ip_redirect", ip, target);
    endtask

    // Fetch completes, then the decoder-side word is flushed while held.
    task automatic hold_flush(input int stall, input bit rdy, input logic [31:0] data, input logic [31:0] target);
        logic [31:0] a;
        idle_cycle(a);
        memAck = 1'b1; memData = data;
        #1;
        chk("hf_upd", {31'd0, ipUpdateEnable}, 32'd1);
        cyc();
        memAck = 1'b0;
        for (int s = 0; s < stall; s++) begin
            #1;
            chk("hf_valid", {31'd0, instrValid}, 32'd1);
            chk("hf_instr", instr, data);
            cyc();
        end
        flush = 1'b1; flush_target = target; instrReady = rdy;
        #1;
        chk("hf_flush_valid", {31'd0, instrValid}, 32'd1);
        chk("hf_flush_upd", {31'd0, ipUpdateEnable}, 32'd0);
        cyc();
        flush = 1'b0; instrReady = 1'b0;
        chk("hf_ip", ip, target);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] tgt;
        int          kind;

        resetEnable = 1'b1; fetchEnable = 1'b0; flush = 1'b0; memAck = 1'b0;
        memData = '0; instrReady = 1'b0; flush_target = '0;
        ip_load = 1'b1; ip_load_val = 32'h100;
        cyc(); cyc();
        #1;
        chk("rst_req", {31'd0, memReq}, 32'd0);
        chk("rst_upd", {31'd0, ipUpdateEnable}, 32'd0);
        chk("rst_valid", {31'd0, instrValid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_iaddr", instrAddr, 32'd0);
        chk("ip_adjust", ipAdjust, 32'd4);
        ip_load = 1'b0;
        resetEnable = 1'b0;
        cyc();

        // Basic fetch with two wait states, then decoder backpressure.
        run_fetch(2, 0, 32'hDEADBEEF, 1'b0);
        run_fetch(0, 5, 32'h12345678, 1'b0);

        // Flush one cycle before ack, with one extra flush while draining.
        flush_fetch(1, 1'b0, 2, 32'h200);
        run_fetch(0, 0, 32'hCAFEF00D, 1'b0);

        // Flush coincident with ack.
        flush_fetch(1, 1'b1, 0, 32'h300);
        run_fetch(1, 1, 32'h0BADC0DE, 1'b0);

        // Misaligned IP raises fault; flush to an aligned target clears it.
        fetchEnable = 1'b0; ip_load = 1'b1; ip_load_val = 32'h102;
        #1;
        chk("park_req0", {31'd0, memReq}, 32'd0);
        cyc();
        ip_load = 1'b0;
        #1;
        chk("park_req1", {31'd0, memReq}, 32'd0);
        cyc();
        fetchEnable = 1'b1;
        #1;
        chk("mis_idle_req", {31'd0, memReq}, 32'd0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fault_flag", {31'd0, fault}, 32'd1);
            chk("fault_req", {31'd0, memReq}, 32'd0);
            chk("fault_valid", {31'd0, instrValid}, 32'd0);
            cyc();
        end
        flush = 1'b1; flush_target = 32'h104;
        #1;
        chk("fault_at_flush", {31'd0, fault}, 32'd1);
        cyc();
        flush = 1'b0;
        chk("fault_ip", ip, 32'h104);
        run_fetch(1, 0, 32'h600DD00D, 1'b0);

        // Asynchronous reset between edges while holding a word.
        idle_cycle(a);
        memAck = 1'b1; memData = 32'hA5A5A5A5;
        cyc();
        memAck = 1'b0; instrReady = 1'b0;
        #1;
        chk("pre_rst_valid", {31'd0, instrValid}, 32'd1);
        #2;
        resetEnable = 1'b1;
        #1;
        chk("arst_valid", {31'd0, instrValid}, 32'd0);
        chk("arst_req", {31'd0, memReq}, 32'd0);
        chk("arst_fault", {31'd0, fault}, 32'd0);
        chk("arst_instr", instr, 32'd0);
        cyc();
        resetEnable = 1'b0;
        run_fetch(0, 0, 32'h13579BDF, 1'b0);

        // Randomized mix of transactions.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            tgt  = ($urandom & 32'h0000_FFFC) | 32'h0001_0000;
            case (kind)
                0, 1: run_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                                ($urandom_range(0, 3) == 0));
                2:    flush_fetch($urandom_range(0, 2), ($urandom_range(0, 1) == 1),
                                  $urandom_range(0, 2), tgt);
                default: hold_flush($urandom_range(0, 2), ($urandom_range(0, 1) == 1),
                                    $urandom, tgt);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
